// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command-frame parser:
// state encoding, error codes, frame constants and timeout derivation.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_D3   = 3'd2,
        ST_D2   = 3'd3,
        ST_D1   = 3'd4,
        ST_D0   = 3'd5,
        ST_CHK  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_FRAME   = 2'd1,
        ERR_CHK     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'h55;
    localparam int         FRAME_LEN      = 7;

    // One byte time is 10 bit times (start + 8 data + stop).
    function automatic int timeout_cycles(input int clock_freq, input int baud,
                                          input int timeout_bytes);
        longint cycles;
        cycles = longint'(timeout_bytes) * 64'sd10 * longint'(clock_freq) / longint'(baud);
        return int'(cycles);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and validated-command output of the UART command parser.
// master = byte receiver / consumer side, slave = the parser itself.
interface uart_cmd_parser_if;
    logic        Rx_Done;
    logic [7:0]  Rx_Data;
    logic        Frame_Error;
    logic        Cmd_Valid;
    logic [7:0]  Cmd_Addr;
    logic [31:0] Cmd_Data;
    logic        Cmd_Err;
    logic [1:0]  Err_Code;

    modport master (
        output Rx_Done, Rx_Data, Frame_Error,
        input  Cmd_Valid, Cmd_Addr, Cmd_Data, Cmd_Err, Err_Code
    );

    modport slave (
        input  Rx_Done, Rx_Data, Frame_Error,
        output Cmd_Valid, Cmd_Addr, Cmd_Data, Cmd_Err, Err_Code
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles HEADER/ADDR/D3..D0/CHK byte frames into checked 8-bit address,
// 32-bit data register writes; reports framing, checksum and timeout errors.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         CLOCK_FREQ    = 50_000_000,
    parameter int         BAUD          = 115200,
    parameter logic [7:0] HEADER        = HEADER_DEFAULT,
    parameter int         TIMEOUT_BYTES = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    uart_cmd_parser_if.slave  bus
);

    localparam int TIMEOUT_CYCLES = timeout_cycles(CLOCK_FREQ, BAUD, TIMEOUT_BYTES);
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state_reg, state_next;
    logic [7:0]       chk_reg, chk_next;
    logic [7:0]       addr_sh_reg, addr_sh_next;
    logic [7:0]       data_sh_reg [4];
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic             cmd_valid_reg, cmd_valid_next;
    logic             cmd_err_reg, cmd_err_next;
    logic [1:0]       err_code_reg, err_code_next;
    logic [7:0]       cmd_addr_reg, cmd_addr_next;
    logic [31:0]      cmd_data_reg, cmd_data_next;

    logic rx_clean, rx_bad, timeout_hit;

    assign rx_clean    = bus.Rx_Done && !bus.Frame_Error;
    assign rx_bad      = bus.Rx_Done &&  bus.Frame_Error;
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state_reg != ST_IDLE) && !bus.Rx_Done &&
                         (to_cnt_reg == TO_W'(TIMEOUT_CYCLES));

    // Data byte lanes: lane gi holds Cmd_Data[8*gi +: 8], received in state D<gi>.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [2:0] LANE_ST = 3'(int'(ST_D0) - gi);
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    data_sh_reg[gi] <= 8'h00;
                end else if (rx_clean && state_reg == state_t'(LANE_ST)) begin
                    data_sh_reg[gi] <= bus.Rx_Data;
                end
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= ST_IDLE;
            chk_reg       <= 8'h00;
            addr_sh_reg   <= 8'h00;
            to_cnt_reg    <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
            err_code_reg  <= ERR_NONE;
            cmd_addr_reg  <= 8'h00;
            cmd_data_reg  <= 32'h0;
        end else begin
            state_reg     <= state_next;
            chk_reg       <= chk_next;
            addr_sh_reg   <= addr_sh_next;
            to_cnt_reg    <= to_cnt_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_err_reg   <= cmd_err_next;
            err_code_reg  <= err_code_next;
            cmd_addr_reg  <= cmd_addr_next;
            cmd_data_reg  <= cmd_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        chk_next       = chk_reg;
        addr_sh_next   = addr_sh_reg;
        cmd_valid_next = 1'b0;
        cmd_err_next   = 1'b0;
        err_code_next  = err_code_reg;
        cmd_addr_next  = cmd_addr_reg;
        cmd_data_next  = cmd_data_reg;

        if (rx_bad) begin
            cmd_err_next  = 1'b1;
            err_code_next = ERR_FRAME;
            state_next    = ST_IDLE;
        end else if (rx_clean) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (bus.Rx_Data == HEADER) begin
                        state_next = ST_ADDR;
                        chk_next   = 8'h00;
                    end
                end
                ST_ADDR: begin
                    addr_sh_next = bus.Rx_Data;
                    chk_next     = chk_reg ^ bus.Rx_Data;
                    state_next   = ST_D3;
                end
                ST_D3: begin
                    chk_next   = chk_reg ^ bus.Rx_Data;
                    state_next = ST_D2;
                end
                ST_D2: begin
                    chk_next   = chk_reg ^ bus.Rx_Data;
                    state_next = ST_D1;
                end
                ST_D1: begin
                    chk_next   = chk_reg ^ bus.Rx_Data;
                    state_next = ST_D0;
                end
                ST_D0: begin
                    chk_next   = chk_reg ^ bus.Rx_Data;
                    state_next = ST_CHK;
                end
                ST_CHK: begin
                    if (bus.Rx_Data == chk_reg) begin
                        cmd_valid_next = 1'b1;
                        cmd_addr_next  = addr_sh_reg;
                        cmd_data_next  = {data_sh_reg[3], data_sh_reg[2],
                                          data_sh_reg[1], data_sh_reg[0]};
                    end else begin
                        cmd_err_next  = 1'b1;
                        err_code_next = ERR_CHK;
                    end
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (timeout_hit) begin
            cmd_err_next  = 1'b1;
            err_code_next = ERR_TIMEOUT;
            state_next    = ST_IDLE;
        end

        // Gap counter measures idle cycles since the last byte of an open frame.
        if (bus.Rx_Done || state_next == ST_IDLE || state_reg == ST_IDLE) begin
            to_cnt_next = '0;
        end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
        end
    end

    assign bus.Cmd_Valid = cmd_valid_reg;
    assign bus.Cmd_Err   = cmd_err_reg;
    assign bus.Err_Code  = err_code_reg;
    assign bus.Cmd_Addr  = cmd_addr_reg;
    assign bus.Cmd_Data  = cmd_data_reg;

endmodule
